// File: rtl/hs_angle_pkg.sv
// rtl/hs_angle_pkg.sv - shared state type, default sizes and bit-reverse helper for hs_angle_seq
package hs_angle_pkg;

    localparam int DEF_ANGLE_W   = 9;
    localparam int DEF_ANGLE_MOD = 180;
    localparam int DEF_IDX_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_VALID,
        ST_DONE
    } state_t;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            r[n - 1 - i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_angle_seq_if.sv
// rtl/hs_angle_seq_if.sv - angle stream handshake between hs_angle_seq and its consumer
interface hs_angle_seq_if
    import hs_angle_pkg::*;
#(
    parameter int ANGLE_W = DEF_ANGLE_W,
    parameter int IDX_W   = DEF_IDX_W
);
    logic [ANGLE_W-1:0] angle;
    logic [IDX_W-1:0]   angle_idx;
    logic               angle_valid;
    logic               angle_ready;

    modport master (
        output angle,
        output angle_idx,
        output angle_valid,
        input  angle_ready
    );

    modport slave (
        input  angle,
        input  angle_idx,
        input  angle_valid,
        output angle_ready
    );
endinterface

// File: rtl/hs_angle_mulmod.sv
// rtl/hs_angle_mulmod.sv - iterative (a + b*c) mod ANGLE_MOD, one multiplier bit per cycle
module hs_angle_mulmod
    import hs_angle_pkg::*;
#(
    parameter int ANGLE_W   = DEF_ANGLE_W,
    parameter int ANGLE_MOD = DEF_ANGLE_MOD,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] a,
    input  logic [ANGLE_W-1:0] b,
    input  logic [IDX_W-1:0]   c,
    output logic               busy,
    output logic [ANGLE_W-1:0] result
);

    localparam int LEFT_W = $clog2(IDX_W + 1);

    logic [ANGLE_W-1:0] acc, addend, cur_acc, cur_add, nxt_acc, nxt_add;
    logic [IDX_W-1:0]   mult;
    logic [LEFT_W-1:0]  left;
    logic               busy_q, cur_bit;

    function automatic logic [ANGLE_W-1:0] mod_add(input logic [ANGLE_W-1:0] x,
                                                   input logic [ANGLE_W-1:0] y);
        logic [ANGLE_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (ANGLE_W + 1)'(ANGLE_MOD)) s = s - (ANGLE_W + 1)'(ANGLE_MOD);
        return s[ANGLE_W-1:0];
    endfunction

    // Bit 0 is folded in on the start edge, so the result lands IDX_W-1 cycles later.
    always_comb begin
        cur_acc = start ? a : acc;
        cur_add = start ? b : addend;
        cur_bit = start ? c[0] : mult[0];
        nxt_acc = cur_bit ? mod_add(cur_acc, cur_add) : cur_acc;
        nxt_add = mod_add(cur_add, cur_add);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= '0;
            addend <= '0;
            mult   <= '0;
            left   <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            acc    <= nxt_acc;
            addend <= nxt_add;
            mult   <= c >> 1;
            left   <= LEFT_W'(IDX_W - 1);
            busy_q <= (IDX_W > 1);
        end else if (busy_q) begin
            acc    <= nxt_acc;
            addend <= nxt_add;
            mult   <= mult >> 1;
            left   <= left - LEFT_W'(1);
            if (left == LEFT_W'(1)) busy_q <= 1'b0;
        end
    end

    assign busy   = busy_q;
    assign result = acc;

endmodule

// File: rtl/hs_angle_seq.sv
// rtl/hs_angle_seq.sv - angle sequence generator; bit-reversed ordering built only with HS_ANGLE_BITREV_EN
module hs_angle_seq
    import hs_angle_pkg::*;
#(
    parameter int ANGLE_W   = DEF_ANGLE_W,
    parameter int ANGLE_MOD = DEF_ANGLE_MOD,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ANGLE_W-1:0] cfg_start,
    input  logic [ANGLE_W-1:0] cfg_step,
    input  logic [IDX_W-1:0]   cfg_count,
    input  logic               cfg_bitrev,
    input  logic               start,
    input  logic               abort,
    hs_angle_seq_if.master     ang,
    output logic               has_next,
    output logic               done,
    output logic               cfg_err
);

    state_t             state;
    logic [ANGLE_W-1:0] start_r, step_r, angle_q, lin_next;
    logic [IDX_W-1:0]   count_r, idx_q;
    logic               valid_q, has_next_q, done_q, cfg_err_q;
    logic               cfg_ok, xfer, last;

    function automatic logic [ANGLE_W-1:0] mod_add(input logic [ANGLE_W-1:0] x,
                                                   input logic [ANGLE_W-1:0] y);
        logic [ANGLE_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= (ANGLE_W + 1)'(ANGLE_MOD)) s = s - (ANGLE_W + 1)'(ANGLE_MOD);
        return s[ANGLE_W-1:0];
    endfunction

    assign cfg_ok   = (cfg_start < ANGLE_W'(ANGLE_MOD)) && (cfg_step < ANGLE_W'(ANGLE_MOD));
    assign xfer     = valid_q && ang.angle_ready;
    assign last     = (idx_q == count_r - IDX_W'(1));
    assign lin_next = mod_add(angle_q, step_r);

`ifdef HS_ANGLE_BITREV_EN
    logic               bitrev_r, mul_start, mul_busy;
    logic [IDX_W-1:0]   rev_q, rev_nxt, mul_c;
    logic [ANGLE_W-1:0] mul_a, mul_b, mul_result;

    // Smallest counter value above rev_q whose reversal lands inside the run.
    always_comb begin
        rev_nxt = rev_q;
        for (int r = (1 << IDX_W) - 1; r > 0; r--) begin
            if (IDX_W'(r) > rev_q && IDX_W'(bit_rev(32'(r), IDX_W)) < count_r)
                rev_nxt = IDX_W'(r);
        end
    end

    always_comb begin
        if (state == ST_IDLE) begin
            mul_a = cfg_start;
            mul_b = cfg_step;
            mul_c = '0;
        end else begin
            mul_a = start_r;
            mul_b = step_r;
            mul_c = IDX_W'(bit_rev(32'(rev_nxt), IDX_W));
        end
    end

    assign mul_start = !abort &&
        ((state == ST_IDLE && start && cfg_ok && cfg_count != '0 && cfg_bitrev) ||
         (state == ST_VALID && xfer && bitrev_r && !last));

    hs_angle_mulmod #(
        .ANGLE_W   (ANGLE_W),
        .ANGLE_MOD (ANGLE_MOD),
        .IDX_W     (IDX_W)
    ) u_mulmod (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .c       (mul_c),
        .busy    (mul_busy),
        .result  (mul_result)
    );
`else
    logic unused_bitrev;
    assign unused_bitrev = cfg_bitrev;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            start_r    <= '0;
            step_r     <= '0;
            count_r    <= '0;
            angle_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            has_next_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
`ifdef HS_ANGLE_BITREV_EN
            bitrev_r   <= 1'b0;
            rev_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                valid_q    <= 1'b0;
                has_next_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        if (!cfg_ok) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            start_r    <= cfg_start;
                            step_r     <= cfg_step;
                            count_r    <= cfg_count;
                            idx_q      <= '0;
                            has_next_q <= 1'b1;
`ifdef HS_ANGLE_BITREV_EN
                            bitrev_r   <= cfg_bitrev;
                            rev_q      <= '0;
`endif
                            if (cfg_count == '0) begin
                                done_q <= 1'b1;
                                state  <= ST_DONE;
                            end
`ifdef HS_ANGLE_BITREV_EN
                            else if (cfg_bitrev) begin
                                state <= ST_CALC;
                            end
`endif
                            else begin
                                angle_q <= cfg_start;
                                valid_q <= 1'b1;
                                state   <= ST_VALID;
                            end
                        end
                    end
`ifdef HS_ANGLE_BITREV_EN
                    ST_CALC: if (!mul_busy) begin
                        angle_q <= mul_result;
                        valid_q <= 1'b1;
                        state   <= ST_VALID;
                    end
`endif
                    ST_VALID: if (xfer) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
`ifdef HS_ANGLE_BITREV_EN
                            if (bitrev_r) begin
                                rev_q   <= rev_nxt;
                                valid_q <= 1'b0;
                                state   <= ST_CALC;
                            end else begin
                                angle_q <= lin_next;
                            end
`else
                            angle_q <= lin_next;
`endif
                        end
                    end
                    ST_DONE: begin
                        has_next_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ang.angle       = angle_q;
    assign ang.angle_idx   = idx_q;
    assign ang.angle_valid = valid_q;
    assign has_next        = has_next_q;
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_hs_angle_seq.sv
// tb/tb_hs_angle_seq.sv - directed self-checking bench for hs_angle_seq (bitrev cases with HS_ANGLE_BITREV_EN)
module tb_hs_angle_seq;

    logic       clk, reset_n, a_start, abort, cfg_bitrev;
    logic [8:0] cfg_start, cfg_step;
    logic [7:0] cfg_count;
    logic       a_has_next, a_done, a_cfg_err;
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_v[8];

    hs_angle_seq_if #(.ANGLE_W(9), .IDX_W(8)) a_if ();

    hs_angle_seq #(.ANGLE_W(9), .ANGLE_MOD(180), .IDX_W(8)) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_count  (cfg_count),
        .cfg_bitrev (1'b0),
        .start      (a_start),
        .abort      (abort),
        .ang        (a_if),
        .has_next   (a_has_next),
        .done       (a_done),
        .cfg_err    (a_cfg_err)
    );

`ifdef HS_ANGLE_BITREV_EN
    logic b_start, b_has_next, b_done, b_cfg_err;
    hs_angle_seq_if #(.ANGLE_W(9), .IDX_W(3)) b_if ();

    hs_angle_seq #(.ANGLE_W(9), .ANGLE_MOD(180), .IDX_W(3)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_count  (cfg_count[2:0]),
        .cfg_bitrev (cfg_bitrev),
        .start      (b_start),
        .abort      (1'b0),
        .ang        (b_if),
        .has_next   (b_has_next),
        .done       (b_done),
        .cfg_err    (b_cfg_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_chk(input string tag, input int ang, input int idx, input int vld);
        check($sformatf("%s_angle", tag), 32'(a_if.angle), ang);
        check($sformatf("%s_idx", tag), 32'(a_if.angle_idx), idx);
        check($sformatf("%s_valid", tag), 32'(a_if.angle_valid), vld);
    endtask

    task automatic go_a(input int s, input int st, input int c);
        cfg_start  = 9'(s);
        cfg_step   = 9'(st);
        cfg_count  = 8'(c);
        cfg_bitrev = 1'b0;
        a_start    = 1'b1;
        tick();
        a_start    = 1'b0;
    endtask

    task automatic a_run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            a_chk($sformatf("%s%0d", tag, k), exp_v[k], k, 1);
            tick();
        end
        check($sformatf("%s_done", tag), 32'(a_done), 1);
        check($sformatf("%s_valid_off", tag), 32'(a_if.angle_valid), 0);
        tick();
        check($sformatf("%s_done_once", tag), 32'(a_done), 0);
        check($sformatf("%s_idle", tag), 32'(a_has_next), 0);
    endtask

`ifdef HS_ANGLE_BITREV_EN
    task automatic b_run(input string tag, input int n);
        int w;
        cfg_start  = 9'd0;
        cfg_step   = 9'd45;
        cfg_count  = 8'(n);
        cfg_bitrev = 1'b1;
        b_start    = 1'b1;
        tick();
        b_start    = 1'b0;
        check($sformatf("%s_calc_busy", tag), 32'(b_has_next), 1);
        for (int k = 0; k < n; k++) begin
            for (w = 0; w < 20 && !b_if.angle_valid; w++) tick();
            check($sformatf("%s%0d_calc_cycles", tag, k), w, 3);
            check($sformatf("%s%0d_valid", tag, k), 32'(b_if.angle_valid), 1);
            check($sformatf("%s%0d_angle", tag, k), 32'(b_if.angle), exp_v[k]);
            check($sformatf("%s%0d_idx", tag, k), 32'(b_if.angle_idx), k);
            tick();
            if (k < n - 1) check($sformatf("%s%0d_calc_valid", tag, k), 32'(b_if.angle_valid), 0);
        end
        check($sformatf("%s_done", tag), 32'(b_done), 1);
        tick();
        check($sformatf("%s_idle", tag), 32'(b_has_next), 0);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        a_start = 1'b0;
        abort = 1'b0;
        cfg_bitrev = 1'b0;
        cfg_start = '0;
        cfg_step = '0;
        cfg_count = '0;
        a_if.angle_ready = 1'b1;
`ifdef HS_ANGLE_BITREV_EN
        b_start = 1'b0;
        b_if.angle_ready = 1'b1;
`endif
        tick();
        tick();
        a_chk("rst", 0, 0, 0);
        check("rst_has_next", 32'(a_has_next), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_cfg_err", 32'(a_cfg_err), 0);
        reset_n = 1'b1;
        tick();

        exp_v = '{0, 20, 40, 60, 80, 0, 0, 0};
        go_a(0, 20, 5);
        a_run("lin", 5);

        exp_v = '{170, 10, 30, 0, 0, 0, 0, 0};
        go_a(170, 20, 3);
        a_run("wrap", 3);

        // Stall at idx 1 for three cycles; a start pulse lands in the middle of the stall.
        exp_v = '{0, 20, 40, 60, 80, 0, 0, 0};
        go_a(0, 20, 5);
        a_chk("bp0", 0, 0, 1);
        tick();
        a_if.angle_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            a_chk($sformatf("bp_stall%0d", j), 20, 1, 1);
            if (j == 1) begin
                cfg_start = 9'd100;
                cfg_step  = 9'd7;
                cfg_count = 8'd2;
                a_start   = 1'b1;
                tick();
                a_start   = 1'b0;
            end else begin
                tick();
            end
        end
        a_if.angle_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            a_chk($sformatf("bp%0d", k), exp_v[k], k, 1);
            tick();
        end
        check("bp_done", 32'(a_done), 1);
        tick();

        go_a(10, 20, 0);
        check("cnt0_done", 32'(a_done), 1);
        check("cnt0_valid", 32'(a_if.angle_valid), 0);
        tick();
        check("cnt0_done_once", 32'(a_done), 0);
        check("cnt0_valid2", 32'(a_if.angle_valid), 0);
        check("cnt0_idle", 32'(a_has_next), 0);

        go_a(0, 180, 5);
        check("err_flag", 32'(a_cfg_err), 1);
        check("err_no_run", 32'(a_has_next), 0);
        check("err_valid", 32'(a_if.angle_valid), 0);
        tick();
        check("err_no_done", 32'(a_done), 0);

        go_a(0, 20, 5);
        tick();
        tick();
        a_chk("ab_pre", 40, 2, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        a_chk("ab_post", 40, 2, 0);
        check("ab_idle", 32'(a_has_next), 0);
        check("ab_no_done", 32'(a_done), 0);
        check("ab_err_sticky", 32'(a_cfg_err), 1);
        tick();
        check("ab_no_done2", 32'(a_done), 0);

        go_a(50, 20, 5);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_chk("rst_mid", 0, 0, 0);
        check("rst_mid_has_next", 32'(a_has_next), 0);
        check("rst_mid_cfg_err", 32'(a_cfg_err), 0);
        tick();

`ifdef HS_ANGLE_BITREV_EN
        exp_v = '{0, 90, 45, 135, 0, 0, 0, 0};
        b_run("br4_", 4);
        exp_v = '{0, 90, 45, 0, 0, 0, 0, 0};
        b_run("br3_", 3);

        cfg_start  = 9'd0;
        cfg_step   = 9'd45;
        cfg_count  = 8'd4;
        cfg_bitrev = 1'b1;
        b_start    = 1'b1;
        tick();
        b_start    = 1'b0;
        check("brst_in_calc", 32'(b_has_next), 1);
        check("brst_calc_valid", 32'(b_if.angle_valid), 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("brst_angle", 32'(b_if.angle), 0);
        check("brst_idx", 32'(b_if.angle_idx), 0);
        check("brst_valid", 32'(b_if.angle_valid), 0);
        check("brst_has_next", 32'(b_has_next), 0);
        check("brst_done", 32'(b_done), 0);
        check("brst_cfg_err", 32'(b_cfg_err), 0);
        for (int j = 0; j < 5; j++) tick();
        check("brst_stays_idle", 32'(b_if.angle_valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
